// File: rtl/bp_me_cce_lat_stats_if.sv
// Sample/drain bus for bp_me_cce_lat_stats.
// slave is the statistics block; master is the sample producer / drain consumer.
interface bp_me_cce_lat_stats_if #(
    parameter int lat_width_p = 32,
    parameter int sum_width_p = 48
);
    logic                   sample_v_i;
    logic                   sample_ready_o;
    logic [1:0]             sample_op_i;
    logic [lat_width_p-1:0] sample_lat_i;
    logic                   dump_i;
    logic                   clear_i;
    logic                   stat_v_o;
    logic [sum_width_p-1:0] stat_data_o;
    logic                   stat_last_o;
    logic                   stat_yumi_i;
    logic                   busy_o;

    modport slave (
        input  sample_v_i, sample_op_i, sample_lat_i, dump_i, clear_i, stat_yumi_i,
        output sample_ready_o, stat_v_o, stat_data_o, stat_last_o, busy_o
    );

    modport master (
        output sample_v_i, sample_op_i, sample_lat_i, dump_i, clear_i, stat_yumi_i,
        input  sample_ready_o, stat_v_o, stat_data_o, stat_last_o, busy_o
    );
endinterface

// File: rtl/bp_me_cce_lat_stats.sv
// Per-op request latency statistics (count, sum, min, max) with a
// valid/yumi serial drain. Define BP_ME_CCE_LAT_STATS_HIST_EN to add an
// 8-bin log2 latency histogram per op, drained after the 16 base words.
module bp_me_cce_lat_stats #(
    parameter int lat_width_p = 32,
    parameter int cnt_width_p = 32,
    parameter int sum_width_p = 48
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_me_cce_lat_stats_if.slave        bus
);
    localparam int num_ops_lp = 4;
`ifdef BP_ME_CCE_LAT_STATS_HIST_EN
    localparam int num_bins_lp  = 8;
    localparam int num_words_lp = 48;
`else
    localparam int num_words_lp = 16;
`endif
    localparam int idx_width_lp = $clog2(num_words_lp);
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_words_lp - 1);

    typedef enum logic {e_idle, e_dump} state_e;

    state_e                  state;
    logic [idx_width_lp-1:0] idx;
    logic                    stat_v, stat_last, busy;

    logic [num_ops_lp-1:0][cnt_width_p-1:0] cnt_q;
    logic [num_ops_lp-1:0][sum_width_p-1:0] sum_q;
    logic [num_ops_lp-1:0][lat_width_p-1:0] min_q, max_q;

    logic                   accept, clear;
    logic [1:0]             op;
    logic [lat_width_p-1:0] lat;
    logic [cnt_width_p-1:0] cnt_nxt;
    logic [sum_width_p:0]   sum_add;
    logic [sum_width_p-1:0] sum_nxt;

    assign op  = bus.sample_op_i;
    assign lat = bus.sample_lat_i;

    // Samples are refused while draining so the drained words stay consistent.
    assign bus.sample_ready_o = (state == e_idle) & ~bus.clear_i;
    assign accept             = bus.sample_v_i & bus.sample_ready_o;
    // dump wins over a simultaneous clear so the pending stats get drained.
    assign clear              = (state == e_idle) & bus.clear_i & ~bus.dump_i;

    // Saturating increments for the selected op.
    assign cnt_nxt = (&cnt_q[op]) ? cnt_q[op] : cnt_q[op] + cnt_width_p'(1);
    assign sum_add = {1'b0, sum_q[op]} + {{(sum_width_p + 1 - lat_width_p){1'b0}}, lat};
    assign sum_nxt = sum_add[sum_width_p] ? '1 : sum_add[sum_width_p-1:0];

    // Drain sequencer: word index walks 0..last on each yumi.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= e_idle;
            idx       <= '0;
            stat_v    <= 1'b0;
            stat_last <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                e_idle: if (bus.dump_i) begin
                    state     <= e_dump;
                    idx       <= '0;
                    stat_v    <= 1'b1;
                    busy      <= 1'b1;
                    stat_last <= 1'b0;
                end
                e_dump: if (bus.stat_yumi_i) begin
                    if (stat_last) begin
                        state     <= e_idle;
                        idx       <= '0;
                        stat_v    <= 1'b0;
                        busy      <= 1'b0;
                        stat_last <= 1'b0;
                    end else begin
                        idx       <= idx + idx_width_lp'(1);
                        stat_last <= (idx == last_idx_lp - idx_width_lp'(1));
                    end
                end
                default: state <= e_idle;
            endcase
        end
    end

    // Base statistics: reset/clear to identity values, update on accept.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else if (accept) begin
            cnt_q[op] <= cnt_nxt;
            sum_q[op] <= sum_nxt;
            if (lat < min_q[op]) min_q[op] <= lat;
            if (lat > max_q[op]) max_q[op] <= lat;
        end
    end

`ifdef BP_ME_CCE_LAT_STATS_HIST_EN
    logic [num_ops_lp-1:0][num_bins_lp-1:0][cnt_width_p-1:0] hist_q;
    logic [2:0]              bin;
    logic [idx_width_lp-1:0] hidx;

    // Bin = highest set bit of the latency, capped at 7; 0 and 1 land in bin 0.
    always_comb begin
        bin = '0;
        for (int i = 1; i < lat_width_p; i++)
            if (lat[i]) bin = (i > 7) ? 3'd7 : 3'(i);
    end

    // Histogram bins saturate like the counts.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            hist_q <= '0;
        else if (clear)
            hist_q <= '0;
        else if (accept && !(&hist_q[op][bin]))
            hist_q[op][bin] <= hist_q[op][bin] + cnt_width_p'(1);
    end
`endif

    // Output word selected purely from registered state, index and stats.
    always_comb begin
        bus.stat_data_o = '0;
`ifdef BP_ME_CCE_LAT_STATS_HIST_EN
        hidx = idx - idx_width_lp'(16);
`endif
        if (state == e_dump) begin
            case (idx[1:0])
                2'd0:    bus.stat_data_o = sum_width_p'(cnt_q[idx[3:2]]);
                2'd1:    bus.stat_data_o = sum_q[idx[3:2]];
                2'd2:    bus.stat_data_o = sum_width_p'(min_q[idx[3:2]]);
                default: bus.stat_data_o = sum_width_p'(max_q[idx[3:2]]);
            endcase
`ifdef BP_ME_CCE_LAT_STATS_HIST_EN
            if (idx >= idx_width_lp'(16))
                bus.stat_data_o = sum_width_p'(hist_q[hidx[4:3]][hidx[2:0]]);
`endif
        end
    end

    assign bus.stat_v_o    = stat_v;
    assign bus.stat_last_o = stat_last;
    assign bus.busy_o      = busy;
endmodule

// File: doc/bp_me_cce_lat_stats.md
# bp_me_cce_lat_stats

Synthesizable latency-statistics accumulator that sits directly downstream of the CCE request-latency measurement stage. It consumes one completion sample per finished LCE request (op class plus measured latency in cycles) and keeps per-op count, latency sum, minimum and maximum. On command it drains everything as a serial word stream over a valid/yumi interface. It gives silicon and FPGA builds the same busy/latency visibility that simulation traces provide.

## Interface
Parameters:
- lat_width_p, 32, width of the sample latency.
- cnt_width_p, 32, width of per-op count and histogram bins.
- sum_width_p, 48, width of per-op latency sum; also the output word width; must be ≥ lat_width_p and ≥ cnt_width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- sample_v_i  in  1  completion sample valid.
- sample_ready_o  out  1  block can accept a sample.
- sample_op_i  in  2  op class: 0=RD, 1=WR, 2=UC_RD, 3=UC_WR.
- sample_lat_i  in  lat_width_p  measured request latency, in cycles.
- dump_i  in  1  single-cycle request to start a drain.
- clear_i  in  1  single-cycle request to zero all statistics.
- stat_v_o  out  1  output word valid.
- stat_data_o  out  sum_width_p  output word, zero-extended.
- stat_last_o  out  1  current word is the final word of the drain.
- stat_yumi_i  in  1  consumer takes the word; legal only while stat_v_o is high.
- busy_o  out  1  drain in progress.

## Operation
- States: IDLE and DUMP. Reset enters IDLE.
- sample_ready_o = (state==IDLE) & ~clear_i. A sample is accepted when sample_v_i & sample_ready_o.
- On acceptance, update op o = sample_op_i:
  - count[o] += 1, saturating at all-ones.
  - sum[o] += zero-extended latency, saturating at all-ones.
  - min[o] = min(min[o], lat).
  - max[o] = max(max[o], lat).
- Reset and clear values: count=0, sum=0, min=all-ones (lat_width_p), max=0.
- IDLE, clear_i=1, dump_i=0: all statistics reset on the next edge.
- IDLE, dump_i=1: go to DUMP and set word index to 0. clear_i in the same cycle is ignored.
- IDLE, dump_i=1 and a sample accepted in the same cycle: the sample is included in the drain.
- DUMP:
  - stat_v_o=1, busy_o=1, sample_ready_o=0.
  - Word order, for op 0..3: count, sum, min, max. That is 16 words.
  - stat_yumi_i advances the index by one.
  - stat_last_o is high on the last word. Its yumi returns the block to IDLE.
  - dump_i and clear_i are ignored while in DUMP.
  - Statistics are not modified by a drain and persist until clear_i.
- stat_data_o is a function of the state and index registers only; no input-to-output combinational path.

## Timing
- Reset values of outputs: sample_ready_o=1 (clear_i low), stat_v_o=0, stat_last_o=0, stat_data_o=0, busy_o=0.
- Asynchronous assertion of reset_i mid-drain aborts the drain immediately. Statistics are zeroed and state returns to IDLE.
- Statistics are visible in a drain started one cycle after the sample's acceptance edge.
- Drain timing:
  - dump_i sampled at edge N gives stat_v_o=1 from cycle N+1.
  - With stat_yumi_i held high, one word transfers per cycle, so a 16-word drain ends with busy_o low at cycle N+17.
  - Back-to-back with no idle cycle: sample_ready_o rises in the same cycle busy_o falls.
- The consumer may stall indefinitely. stat_data_o and stat_last_o must hold stable while stat_v_o=1 and stat_yumi_i=0.

## Configuration
- BP_ME_CCE_LAT_STATS_HIST_EN defined: adds an 8-bin log2 histogram per op.
  - Bin b = min(floor(log2(max(lat,1))), 7). Latencies 0 and 1 go to bin 0; latency ≥128 goes to bin 7.
  - Bins are cnt_width_p wide, saturating, and cleared with the other statistics.
  - Bins are drained after the 16 base words: op0 bins 0..7, then op1, and so on. The drain is 48 words and stat_last_o marks word 47.
- Not defined: no histogram storage or logic, and the drain is exactly 16 words.

## Test plan
- Reset, then dump_i with stat_yumi_i=1: 16 words in order 0,0,all-ones,0 repeated per op; stat_last_o on word 15; busy_o low 17 cycles after dump_i.
- Samples RD lat 5, RD lat 12, WR lat 3, then drain: RD words 2,17,5,12; WR words 1,3,3,3; UC ops remain at reset values.
- Sample and dump_i in the same cycle, then toggle stat_yumi_i randomly during the drain: the sample appears in the drain, data is stable while stalled, and sample_ready_o stays 0 until after the last yumi.
- Preload count[RD] near saturation (cnt_width_p=4): 20 RD samples give count 15, and sum saturates correctly with lat_width_p=4 and sum_width_p=4.
- clear_i and dump_i together, then clear_i alone: the first drain shows the prior statistics; after the clear, the next drain shows reset values. Assert reset_i low mid-drain: stat_v_o drops immediately.
- With HIST_EN, UC_WR latencies 0,1,2,3,200: UC_WR bins are 2,2,0,0,0,0,0,1; drain is 48 words.
